bus_arbiter_rr16: RTL and testbench
===================================

# bus_arbiter_rr16

Round-robin arbiter and sequencer for the 16-source tri-state shared line. Sixteen requesters compete for the line. The block grants one requester at a time and drives the 4-bit select into the 4-to-16 decoder. It also provides a decoder enable that turns all bus drivers off between owners, which gives one turnaround cycle so no two tri-state buffers ever drive the line at once. Ownership is capped at MAX_BEATS cycles so no requester can starve the others.

## Interface
- MAX_BEATS, 8, maximum consecutive grant cycles per ownership; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request vector; req[i] high = requester i wants the line; held high for as long as it wants ownership.
- S  output  4  select to the decoder; index of current or most recent owner.
- bus_en  output  1  decoder enable; 0 forces all 16 buffers to high-Z.
- gnt  output  16  one-hot grant, all-zero when bus_en = 0.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, GRANT, GAP. All outputs are registered.
- Round-robin pointer `ptr` (4 bits, reset 0): the winner is the first i with req[i] = 1, searching ptr, ptr+1, …, 15, 0, …, ptr−1 (mod 16).
- IDLE:
  - If any req bit is set → GRANT, with S = winner, gnt = 1<<winner, bus_en = 1, beat counter cnt = 1.
  - Otherwise stay in IDLE.
- GRANT:
  - If req[S] = 0 or cnt = MAX_BEATS → GAP, with bus_en = 0, gnt = 0, S held, ptr = S+1 (15 wraps to 0).
  - Otherwise cnt = cnt+1 and the grant is held.
- GAP: lasts exactly one cycle, with bus_en = 0.
  - Arbitration uses the updated ptr.
  - If any req bit is set → GRANT to the winner (cnt = 1); otherwise → IDLE.
- Fairness: the owner just released has the lowest priority in the next arbitration. It regains the line back-to-back only if no other requester is active.
- A req change by any non-owner during GRANT has no effect until the next arbitration.
- Reset values: state IDLE, S = 0, bus_en = 0, gnt = 0, busy = 0, ptr = 0, cnt = 0.
- Invariants:
  - gnt is either zero or one-hot.
  - gnt != 0 exactly when bus_en = 1.
  - When bus_en = 1, gnt[S] = 1.

## Timing
- Grant latency: req first sampled high at edge k while in IDLE → gnt/bus_en high from edge k onward (visible in the cycle after edge k).
- Release: req[S] sampled low at edge k during GRANT → bus_en low from edge k. A requester that drops req after n grant cycles owns exactly n cycles.
- Cap: with req held, the owner gets exactly MAX_BEATS consecutive cycles of bus_en = 1, followed by one GAP cycle.
- Handover: there is always exactly one bus_en = 0 cycle between two different owners, and also between two grants to the same owner. bus_en never stays high across an owner change.
- Simultaneous release and cap (req[S] drops at the same edge cnt = MAX_BEATS): one transition to GAP, with no double pointer advance.
- MAX_BEATS = 1: every grant lasts one cycle, alternating GRANT/GAP.
- Reset mid-operation: outputs reach their reset values immediately, without waiting for a clock edge. The first edge after rst falls evaluates from IDLE with ptr = 0.

## Test plan
- Reset and idle: assert rst with req = 16'hFFFF, then release rst.
  - While rst is high: bus_en = 0, gnt = 0, S = 0.
  - At the first edge after release: gnt = 16'h0001, S = 0.
- Single requester: req[5] high for 3 cycles, then low.
  - gnt = 16'h0020, S = 5, bus_en = 1 for exactly 3 cycles.
  - Then 1 GAP cycle (bus_en = 0), then IDLE with busy = 0.
- Full contention with MAX_BEATS = 8 and req = 16'hFFFF held:
  - Grants run 0, 1, …, 15, 0, each lasting 8 cycles, separated by single bus_en = 0 cycles.
  - A 9-cycle period per owner.
- Wrap-around priority: after the owner is 14, req = bits {3, 14, 15} held.
  - Next grants are 15, then 3, then 14.
- Back-to-back same owner: only req[7] held with MAX_BEATS = 4.
  - Pattern is 4 cycles gnt[7] and 1 gap cycle, repeated; S stays 7 throughout.
- Reset mid-grant: assert rst asynchronously during cycle 2 of grant to 9.
  - bus_en and gnt drop before the next clock edge.
  - After release with req[9] and req[2] high, the first grant goes to 2 (ptr = 0).

Source files
------------

// File: rtl/bus_arbiter_rr16_if.sv
// Request/grant bundle shared by the 16 requesters and the round-robin arbiter.
// The arbiter takes the slave view; requesters take the master view.
interface bus_arbiter_rr16_if;
   logic [15:0] req;
   logic [3:0]  S;
   logic        bus_en;
   logic [15:0] gnt;
   logic        busy;

   modport master (output req, input S, input bus_en, input gnt, input busy);
   modport slave  (input req, output S, output bus_en, output gnt, output busy);
endinterface

// File: rtl/bus_arbiter_rr16.sv
// Round-robin arbiter for a 16-source tri-state line. One owner at a time,
// ownership capped at MAX_BEATS cycles, one idle turnaround cycle between grants.
module bus_arbiter_rr16 #(
   parameter int unsigned MAX_BEATS = 8
) (
   input logic              clk,
   input logic              rst,
   bus_arbiter_rr16_if.slave bus
);
   localparam int unsigned N_REQ = 16;
   localparam int unsigned SEL_W = 4;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   s_q, s_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               bus_en_q, bus_en_d;
   logic               busy_q, busy_d;

   logic [SEL_W-1:0]   win;
   logic [SEL_W-1:0]   idx;
   logic               found;
   logic               any_req;

   assign any_req = |bus.req;

   // First requester at or after ptr, wrapping modulo 16
   always_comb begin
      win   = ptr_q;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         idx = SEL_W'(ptr_q + SEL_W'(i));
         if (!found && bus.req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      bus_en_d = bus_en_q;

      unique case (state_q)
         IDLE, GAP: begin
            // In GAP the pointer was already advanced past the released owner
            gnt_d    = '0;
            bus_en_d = 1'b0;
            if (any_req) begin
               state_d  = GRANT;
               s_d      = win;
               gnt_d    = N_REQ'(1) << win;
               bus_en_d = 1'b1;
               cnt_d    = CNT_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!bus.req[s_q] || (cnt_q == CNT_W'(MAX_BEATS))) begin
               state_d  = GAP;
               gnt_d    = '0;
               bus_en_d = 1'b0;
               ptr_d    = s_q + SEL_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            bus_en_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         s_q      <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         gnt_q    <= '0;
         bus_en_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         bus_en_q <= bus_en_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.S      = s_q;
   assign bus.gnt    = gnt_q;
   assign bus.bus_en = bus_en_q;
   assign bus.busy   = busy_q;
endmodule

// File: tb/tb_bus_arbiter_rr16.sv
// Directed bench for bus_arbiter_rr16: one instance with MAX_BEATS=8, one with 4.
module tb_bus_arbiter_rr16;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   bus_arbiter_rr16_if bif8 ();
   bus_arbiter_rr16_if bif4 ();

   bus_arbiter_rr16 #(.MAX_BEATS(8)) dut8 (.clk(clk), .rst(rst), .bus(bif8.slave));
   bus_arbiter_rr16 #(.MAX_BEATS(4)) dut4 (.clk(clk), .rst(rst), .bus(bif4.slave));

   always #5 clk = ~clk;

   // Outputs are sampled and inputs driven 1 time unit after each rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bif8.req = 16'hFFFF;
      bif4.req = 16'h0000;
      #1 rst = 1'b1;
      #1;
      checks++; if (bif8.bus_en !== 1'b0) begin errors++; $display("FAIL reset_bus_en: got %b want 0", bif8.bus_en); end
      checks++; if (bif8.gnt !== 16'h0000) begin errors++; $display("FAIL reset_gnt: got %h want 0000", bif8.gnt); end
      checks++; if (bif8.S !== 4'd0) begin errors++; $display("FAIL reset_S: got %0d want 0", bif8.S); end
      checks++; if (bif8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bif8.busy); end
      tick; tick;
      checks++; if (bif8.gnt !== 16'h0000) begin errors++; $display("FAIL reset_held_gnt: got %h want 0000", bif8.gnt); end
      rst = 1'b0;
      tick;
      checks++; if (bif8.gnt !== 16'h0001) begin errors++; $display("FAIL reset_first_gnt: got %h want 0001", bif8.gnt); end
      checks++; if (bif8.S !== 4'd0) begin errors++; $display("FAIL reset_first_S: got %0d want 0", bif8.S); end
      checks++; if (bif8.bus_en !== 1'b1) begin errors++; $display("FAIL reset_first_bus_en: got %b want 1", bif8.bus_en); end
      bif8.req = 16'h0000;
      tick; tick;
      checks++; if (bif8.busy !== 1'b0) begin errors++; $display("FAIL reset_drain_busy: got %b want 0", bif8.busy); end
   endtask

   task automatic test_single;
      bif8.req = 16'h0020;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (bif8.gnt !== 16'h0020 || bif8.S !== 4'd5 || bif8.bus_en !== 1'b1) begin
            errors++; $display("FAIL single_grant[%0d]: got gnt=%h S=%0d en=%b want 0020 5 1", i, bif8.gnt, bif8.S, bif8.bus_en);
         end
         if (i == 2) bif8.req = 16'h0000;
      end
      tick;
      checks++; if (bif8.bus_en !== 1'b0 || bif8.gnt !== 16'h0000 || bif8.busy !== 1'b1 || bif8.S !== 4'd5) begin
         errors++; $display("FAIL single_gap: got en=%b gnt=%h busy=%b S=%0d want 0 0000 1 5", bif8.bus_en, bif8.gnt, bif8.busy, bif8.S);
      end
      tick;
      checks++; if (bif8.busy !== 1'b0 || bif8.bus_en !== 1'b0) begin
         errors++; $display("FAIL single_idle: got busy=%b en=%b want 0 0", bif8.busy, bif8.bus_en);
      end
   endtask

   task automatic test_contention;
      logic [15:0] eg;
      logic [3:0]  es;
      rst = 1'b1; #1 rst = 1'b0;
      bif8.req = 16'hFFFF;
      for (int o = 0; o < 17; o++) begin
         eg = 16'(1) << (o % 16);
         es = 4'(o % 16);
         for (int b = 0; b < 8; b++) begin
            tick;
            checks++; if (bif8.gnt !== eg || bif8.S !== es || bif8.bus_en !== 1'b1) begin
               errors++; $display("FAIL contention_owner%0d_beat%0d: got gnt=%h S=%0d en=%b want %h %0d 1", o, b, bif8.gnt, bif8.S, bif8.bus_en, eg, es);
            end
         end
         if (o < 16) begin
            tick;
            checks++; if (bif8.bus_en !== 1'b0 || bif8.gnt !== 16'h0000) begin
               errors++; $display("FAIL contention_gap%0d: got en=%b gnt=%h want 0 0000", o, bif8.bus_en, bif8.gnt);
            end
         end
      end
      bif8.req = 16'h0000;
      tick; tick;
   endtask

   task automatic test_wrap;
      logic [3:0]  seq [3];
      logic [15:0] eg;
      seq[0] = 4'd15; seq[1] = 4'd3; seq[2] = 4'd14;
      rst = 1'b1; #1 rst = 1'b0;
      bif8.req = 16'h4000;
      tick;
      bif8.req = 16'hC008;
      for (int b = 1; b < 8; b++) begin
         tick;
         checks++; if (bif8.gnt !== 16'h4000 || bif8.S !== 4'd14) begin
            errors++; $display("FAIL wrap_first14_beat%0d: got gnt=%h S=%0d want 4000 14", b, bif8.gnt, bif8.S);
         end
      end
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++; if (bif8.bus_en !== 1'b0) begin errors++; $display("FAIL wrap_gap%0d: got en=%b want 0", k, bif8.bus_en); end
         eg = 16'(1) << seq[k];
         for (int b = 0; b < 8; b++) begin
            tick;
            checks++; if (bif8.gnt !== eg || bif8.S !== seq[k]) begin
               errors++; $display("FAIL wrap_owner%0d_beat%0d: got gnt=%h S=%0d want %h %0d", k, b, bif8.gnt, bif8.S, eg, seq[k]);
            end
         end
      end
      // Drop req at the same edge the cap hits: pointer must advance only once
      bif8.req = 16'h0000;
      tick;
      checks++; if (bif8.bus_en !== 1'b0 || bif8.busy !== 1'b1) begin
         errors++; $display("FAIL capdrop_gap: got en=%b busy=%b want 0 1", bif8.bus_en, bif8.busy);
      end
      tick;
      checks++; if (bif8.busy !== 1'b0) begin errors++; $display("FAIL capdrop_idle: got busy=%b want 0", bif8.busy); end
      bif8.req = 16'h8001;
      tick;
      checks++; if (bif8.gnt !== 16'h8000 || bif8.S !== 4'd15) begin
         errors++; $display("FAIL capdrop_ptr: got gnt=%h S=%0d want 8000 15", bif8.gnt, bif8.S);
      end
      bif8.req = 16'h0000;
      tick; tick;
   endtask

   task automatic test_back_to_back;
      bif4.req = 16'h0080;
      for (int r = 0; r < 3; r++) begin
         for (int b = 0; b < 4; b++) begin
            tick;
            checks++; if (bif4.gnt !== 16'h0080 || bif4.S !== 4'd7 || bif4.bus_en !== 1'b1) begin
               errors++; $display("FAIL b2b_round%0d_beat%0d: got gnt=%h S=%0d en=%b want 0080 7 1", r, b, bif4.gnt, bif4.S, bif4.bus_en);
            end
         end
         tick;
         checks++; if (bif4.bus_en !== 1'b0 || bif4.gnt !== 16'h0000 || bif4.S !== 4'd7) begin
            errors++; $display("FAIL b2b_gap%0d: got en=%b gnt=%h S=%0d want 0 0000 7", r, bif4.bus_en, bif4.gnt, bif4.S);
         end
      end
      bif4.req = 16'h0000;
      tick; tick;
   endtask

   task automatic test_reset_mid;
      rst = 1'b1; #1 rst = 1'b0;
      bif8.req = 16'h0200;
      tick; tick;
      checks++; if (bif8.gnt !== 16'h0200) begin errors++; $display("FAIL midrst_pre_gnt: got %h want 0200", bif8.gnt); end
      #3 rst = 1'b1;
      #1;
      checks++; if (bif8.bus_en !== 1'b0 || bif8.gnt !== 16'h0000) begin
         errors++; $display("FAIL midrst_async: got en=%b gnt=%h want 0 0000", bif8.bus_en, bif8.gnt);
      end
      checks++; if (bif8.S !== 4'd0 || bif8.busy !== 1'b0) begin
         errors++; $display("FAIL midrst_async_S_busy: got S=%0d busy=%b want 0 0", bif8.S, bif8.busy);
      end
      bif8.req = 16'h0204;
      #2 rst = 1'b0;
      tick;
      checks++; if (bif8.gnt !== 16'h0004 || bif8.S !== 4'd2) begin
         errors++; $display("FAIL midrst_regrant: got gnt=%h S=%0d want 0004 2", bif8.gnt, bif8.S);
      end
      bif8.req = 16'h0000;
      tick; tick;
   endtask

   initial begin
      test_reset;
      test_single;
      test_contention;
      test_wrap;
      test_back_to_back;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
